// File: rtl/dispatch_unit_if.sv
`default_nettype none
// ============================================================================
// dispatch_unit_if : fetch, issue and result-broadcast signals of dispatch
// Revision: 1.0
// ============================================================================
interface dispatch_unit_if;
  logic        in_valid1;
  logic        in_valid2;
  logic [31:0] in_inst1;
  logic [31:0] in_inst2;
  logic [15:0] in_pc1;
  logic [15:0] in_pc2;
  logic        in_take1;
  logic        in_take2;
  logic        stall;
  logic [39:0] addbus;
  logic [39:0] multbus;
  logic [39:0] loadbus;
  logic [39:0] instbus1;
  logic [39:0] instbus2;
  logic        inst_valid1;
  logic        inst_valid2;
  logic [15:0] pc1;
  logic [15:0] pc2;
  logic        illegal_op;

  modport slave (
    input  in_valid1, in_valid2, in_inst1, in_inst2, in_pc1, in_pc2,
    input  stall, addbus, multbus, loadbus,
    output in_take1, in_take2, instbus1, instbus2,
    output inst_valid1, inst_valid2, pc1, pc2, illegal_op
  );

  modport master (
    output in_valid1, in_valid2, in_inst1, in_inst2, in_pc1, in_pc2,
    output stall, addbus, multbus, loadbus,
    input  in_take1, in_take2, instbus1, instbus2,
    input  inst_valid1, inst_valid2, pc1, pc2, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/dispatch_unit.sv
`default_nettype none
// ============================================================================
// dispatch_unit : dual-issue in-order dispatch with RS tag allocation/renaming
// Revision: 1.0
// ============================================================================
module dispatch_unit #(
  parameter int NUM_ADD = 3,
  parameter int NUM_MUL = 2,
  parameter int NUM_LD  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  dispatch_unit_if.slave du
);

  localparam int          c_ntag       = NUM_ADD + NUM_MUL + NUM_LD;
  localparam int          c_idx_w      = (c_ntag > 1) ? $clog2(c_ntag) : 1;
  localparam logic [7:0]  c_op_add     = 8'h01;
  localparam logic [7:0]  c_op_sub     = 8'h02;
  localparam logic [7:0]  c_op_mul     = 8'h03;
  localparam logic [7:0]  c_op_ld      = 8'h04;
  localparam logic [5:0]  c_reg_base   = 6'b000100;
  localparam logic [31:0] c_page_fault = 32'hffff_ffff;

  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_MUL = 2'd1,
    CLS_LD  = 2'd2,
    CLS_ILL = 2'd3
  } cls_e;

  typedef logic [3:0][7:0] status_t;

  function automatic cls_e decode(input logic [7:0] op);
    case (op)
      c_op_add, c_op_sub: return CLS_ADD;
      c_op_mul:           return CLS_MUL;
      c_op_ld:            return CLS_LD;
      default:            return CLS_ILL;
    endcase
  endfunction

  // Tag index range per class; tag value is index + 1. Illegal gets an empty range.
  function automatic int cls_lo(input cls_e c);
    case (c)
      CLS_ADD: return 0;
      CLS_MUL: return NUM_ADD;
      CLS_LD:  return NUM_ADD + NUM_MUL;
      default: return c_ntag;
    endcase
  endfunction

  function automatic int cls_hi(input cls_e c);
    case (c)
      CLS_ADD: return NUM_ADD - 1;
      CLS_MUL: return NUM_ADD + NUM_MUL - 1;
      CLS_LD:  return c_ntag - 1;
      default: return -1;
    endcase
  endfunction

  function automatic logic is_reg(input logic [7:0] f);
    return (f[7:2] == c_reg_base);
  endfunction

  function automatic logic [7:0] rename(input logic [7:0] src, input status_t st);
    if (is_reg(src) && (st[src[1:0]] != 8'h00)) return st[src[1:0]];
    return src;
  endfunction

  logic [c_ntag-1:0] busy_q, busy_d;
  status_t           status_q, status_d;
  logic [39:0]       instbus1_q, instbus2_q;
  logic [15:0]       pc1_q, pc2_q;
  logic              valid1_q, valid2_q, illegal_q;

  logic [7:0]         w_op1, w_sa1, w_sb1, w_d1;
  logic [7:0]         w_op2, w_sa2, w_sb2, w_d2;
  cls_e               w_cls1, w_cls2;
  logic               w_ill1, w_ill2;
  logic               w_found1, w_found2;
  logic [c_idx_w-1:0] w_idx1, w_idx2;
  logic [7:0]         w_tag1, w_tag2;
  logic               w_take1, w_take2, w_issue1, w_issue2, w_illegal;
  logic [39:0]        w_bus1, w_bus2;
  logic [2:0][7:0]    w_bc_tag;
  logic [2:0]         w_bc_en;

  assign {w_op1, w_sa1, w_sb1, w_d1} = du.in_inst1;
  assign {w_op2, w_sa2, w_sb2, w_d2} = du.in_inst2;
  assign w_cls1 = decode(w_op1);
  assign w_cls2 = decode(w_op2);
  assign w_ill1 = (w_cls1 == CLS_ILL);
  assign w_ill2 = (w_cls2 == CLS_ILL);

  // Lowest free tag per slot; slot 2 must not reuse the tag slot 1 just claimed.
  always_comb begin : free_search
    logic [c_ntag-1:0] busy2;
    w_found1 = 1'b0;
    w_idx1   = '0;
    w_found2 = 1'b0;
    w_idx2   = '0;
    for (int i = c_ntag - 1; i >= 0; i--) begin
      if ((i >= cls_lo(w_cls1)) && (i <= cls_hi(w_cls1)) && !busy_q[i]) begin
        w_found1 = 1'b1;
        w_idx1   = i[c_idx_w-1:0];
      end
    end
    busy2 = busy_q;
    if (w_found1 && (w_cls2 == w_cls1)) busy2[w_idx1] = 1'b1;
    for (int i = c_ntag - 1; i >= 0; i--) begin
      if ((i >= cls_lo(w_cls2)) && (i <= cls_hi(w_cls2)) && !busy2[i]) begin
        w_found2 = 1'b1;
        w_idx2   = i[c_idx_w-1:0];
      end
    end
  end

  assign w_tag1 = 8'(w_idx1) + 8'd1;
  assign w_tag2 = 8'(w_idx2) + 8'd1;

  assign w_take1   = rst_n & du.in_valid1 & ~du.stall & (w_ill1 | w_found1);
  assign w_issue1  = w_take1 & ~w_ill1;
  assign w_take2   = w_issue1 & du.in_valid2 & (w_ill2 | w_found2);
  assign w_issue2  = w_take2 & ~w_ill2;
  assign w_illegal = (w_take1 & w_ill1) | (w_take2 & w_ill2);

  // Slot 2 sees slot 1's destination before the status table does.
  assign w_bus1 = {w_tag1, w_op1, rename(w_sa1, status_q), rename(w_sb1, status_q), w_d1};
  assign w_bus2 = {w_tag2, w_op2,
                   (w_sa2 == w_d1) ? w_tag1 : rename(w_sa2, status_q),
                   (w_sb2 == w_d1) ? w_tag1 : rename(w_sb2, status_q),
                   w_d2};

  assign w_bc_tag = {du.loadbus[39:32], du.multbus[39:32], du.addbus[39:32]};
  assign w_bc_en  = {(du.loadbus[39:32] != 8'h00) && (du.loadbus[31:0] != c_page_fault),
                     (du.multbus[39:32] != 8'h00),
                     (du.addbus[39:32] != 8'h00)};

  // Broadcast clears first, issue writes afterwards so an issue wins a collision.
  always_comb begin : state_next
    busy_d   = busy_q;
    status_d = status_q;
    for (int b = 0; b < 3; b++) begin
      if (w_bc_en[b]) begin
        for (int i = 0; i < c_ntag; i++) begin
          if (w_bc_tag[b] == 8'(i + 1)) busy_d[i] = 1'b0;
        end
        for (int r = 0; r < 4; r++) begin
          if (status_q[r] == w_bc_tag[b]) status_d[r] = 8'h00;
        end
      end
    end
    if (w_issue1) begin
      busy_d[w_idx1] = 1'b1;
      if (is_reg(w_d1)) status_d[w_d1[1:0]] = w_tag1;
    end
    if (w_issue2) begin
      busy_d[w_idx2] = 1'b1;
      if (is_reg(w_d2)) status_d[w_d2[1:0]] = w_tag2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      status_q   <= '0;
      instbus1_q <= 40'h0;
      instbus2_q <= 40'h0;
      pc1_q      <= 16'h0;
      pc2_q      <= 16'h0;
      valid1_q   <= 1'b0;
      valid2_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      status_q  <= status_d;
      valid1_q  <= w_issue1;
      valid2_q  <= w_issue2;
      illegal_q <= w_illegal;
      if (w_issue1) begin
        instbus1_q <= w_bus1;
        pc1_q      <= du.in_pc1;
      end
      if (w_issue2) begin
        instbus2_q <= w_bus2;
        pc2_q      <= du.in_pc2;
      end
    end
  end

  assign du.in_take1    = w_take1;
  assign du.in_take2    = w_take2;
  assign du.instbus1    = instbus1_q;
  assign du.instbus2    = instbus2_q;
  assign du.pc1         = pc1_q;
  assign du.pc2         = pc2_q;
  assign du.inst_valid1 = valid1_q;
  assign du.inst_valid2 = valid2_q;
  assign du.illegal_op  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dispatch_unit : scoreboard bench for the dual-issue dispatch stage
// Revision: 1.0
// ============================================================================
module tb_dispatch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dispatch_unit_if bus_if ();

  dispatch_unit #(
    .NUM_ADD (3),
    .NUM_MUL (2),
    .NUM_LD  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .du    (bus_if.slave)
  );

  typedef struct {
    logic        slot2;
    logic [39:0] bus;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push_exp(input logic s2, input logic [39:0] b, input logic [15:0] p);
    exp_t e;
    e.slot2 = s2;
    e.bus   = b;
    e.pc    = p;
    exp_q.push_back(e);
  endtask

  task automatic slots(input logic v1, input logic [31:0] i1, input logic [15:0] p1,
                       input logic v2, input logic [31:0] i2, input logic [15:0] p2);
    bus_if.in_valid1 = v1;
    bus_if.in_inst1  = i1;
    bus_if.in_pc1    = p1;
    bus_if.in_valid2 = v2;
    bus_if.in_inst2  = i2;
    bus_if.in_pc2    = p2;
  endtask

  task automatic idle_inputs();
    slots(1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 16'h0);
    bus_if.stall   = 1'b0;
    bus_if.addbus  = 40'h0;
    bus_if.multbus = 40'h0;
    bus_if.loadbus = 40'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pops the scoreboard on every issue strobe, slot 1 before slot 2.
  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.inst_valid1 === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL slot1_issue: unexpected strobe bus=%h pc=%h, none expected",
                   bus_if.instbus1, bus_if.pc1);
        end else begin
          e = exp_q.pop_front();
          if (e.slot2 !== 1'b0 || bus_if.instbus1 !== e.bus || bus_if.pc1 !== e.pc) begin
            n_fail++;
            $display("FAIL slot1_issue: got slot1 bus=%h pc=%h, expected slot%0d bus=%h pc=%h",
                     bus_if.instbus1, bus_if.pc1, e.slot2 + 1, e.bus, e.pc);
          end
        end
      end
      if (bus_if.inst_valid2 === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL slot2_issue: unexpected strobe bus=%h pc=%h, none expected",
                   bus_if.instbus2, bus_if.pc2);
        end else begin
          e = exp_q.pop_front();
          if (e.slot2 !== 1'b1 || bus_if.instbus2 !== e.bus || bus_if.pc2 !== e.pc) begin
            n_fail++;
            $display("FAIL slot2_issue: got slot2 bus=%h pc=%h, expected slot%0d bus=%h pc=%h",
                     bus_if.instbus2, bus_if.pc2, e.slot2 + 1, e.bus, e.pc);
          end
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected issues never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    slots(1'b1, 32'h01_10_12_11, 16'h0010, 1'b1, 32'h03_11_11_13, 16'h0014);
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus_if.in_take1, bus_if.in_take2} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_take: got %b, required 00", {bus_if.in_take1, bus_if.in_take2});
    end
    n_checks++;
    if ({bus_if.instbus1, bus_if.instbus2} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_instbus: got %h %h, required 0 0", bus_if.instbus1, bus_if.instbus2);
    end
    n_checks++;
    if ({bus_if.pc1, bus_if.pc2} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: got %h %h, required 0 0", bus_if.pc1, bus_if.pc2);
    end
    n_checks++;
    if ({bus_if.inst_valid1, bus_if.inst_valid2, bus_if.illegal_op} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, required 000",
               {bus_if.inst_valid1, bus_if.inst_valid2, bus_if.illegal_op});
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_dual_issue();
    do_reset();
    @(negedge clk);
    slots(1'b1, 32'h01_10_12_11, 16'h0100, 1'b1, 32'h03_11_11_13, 16'h0104);
    #1;
    n_checks++;
    if ({bus_if.in_take1, bus_if.in_take2} !== 2'b11) begin
      n_fail++;
      $display("FAIL dual_take: got %b, required 11", {bus_if.in_take1, bus_if.in_take2});
    end
    push_exp(1'b0, 40'h01_01_10_12_11, 16'h0100);
    push_exp(1'b1, 40'h04_03_01_01_13, 16'h0104);
    tick();
    @(negedge clk);
    idle_inputs();
    tick();
    check_drained("dual");
  endtask

  task automatic test_add_exhaust();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      slots(1'b1, 32'h01_12_10_12, 16'h0200 + 16'(4 * k), 1'b0, 32'h0, 16'h0);
      #1;
      n_checks++;
      if (bus_if.in_take1 !== 1'b1) begin
        n_fail++;
        $display("FAIL exhaust_take%0d: got %b, required 1", k, bus_if.in_take1);
      end
      case (k)
        0:       push_exp(1'b0, 40'h01_01_12_10_12, 16'h0200);
        1:       push_exp(1'b0, 40'h02_01_01_10_12, 16'h0204);
        default: push_exp(1'b0, 40'h03_01_02_10_12, 16'h0208);
      endcase
      tick();
    end
    @(negedge clk);
    slots(1'b1, 32'h01_12_10_12, 16'h020C, 1'b0, 32'h0, 16'h0);
    #1;
    n_checks++;
    if (bus_if.in_take1 !== 1'b0) begin
      n_fail++;
      $display("FAIL exhaust_full_take: got %b, required 0", bus_if.in_take1);
    end
    tick();
    n_checks++;
    if (bus_if.inst_valid1 !== 1'b0 || bus_if.instbus1 !== 40'h03_01_02_10_12) begin
      n_fail++;
      $display("FAIL exhaust_hold: got valid=%b bus=%h, required 0 030102 1012",
               bus_if.inst_valid1, bus_if.instbus1);
    end
    @(negedge clk);
    bus_if.addbus = {8'h02, 32'h0000_1234};
    #1;
    n_checks++;
    if (bus_if.in_take1 !== 1'b0) begin
      n_fail++;
      $display("FAIL exhaust_free_edge_take: got %b, required 0", bus_if.in_take1);
    end
    tick();
    @(negedge clk);
    bus_if.addbus = 40'h0;
    #1;
    n_checks++;
    if (bus_if.in_take1 !== 1'b1) begin
      n_fail++;
      $display("FAIL exhaust_reuse_take: got %b, required 1", bus_if.in_take1);
    end
    push_exp(1'b0, 40'h02_01_03_10_12, 16'h020C);
    tick();
    @(negedge clk);
    idle_inputs();
    tick();
    check_drained("exhaust");
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    slots(1'b1, 32'h01_10_10_11, 16'h0300, 1'b0, 32'h0, 16'h0);
    push_exp(1'b0, 40'h01_01_10_10_11, 16'h0300);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus_if.stall  = 1'b1;
      bus_if.addbus = (k == 1) ? {8'h01, 32'h0000_0042} : 40'h0;
      slots(1'b1, 32'h01_11_10_12, 16'h0304, 1'b1, 32'h04_12_00_13, 16'h0306);
      #1;
      n_checks++;
      if ({bus_if.in_take1, bus_if.in_take2} !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_take%0d: got %b, required 00", k, {bus_if.in_take1, bus_if.in_take2});
      end
      tick();
      n_checks++;
      if (bus_if.inst_valid1 !== 1'b0 || bus_if.instbus1 !== 40'h01_01_10_10_11 ||
          bus_if.instbus2 !== 40'h0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got valid=%b bus1=%h bus2=%h, required 0 0101101011 0",
                 k, bus_if.inst_valid1, bus_if.instbus1, bus_if.instbus2);
      end
    end
    @(negedge clk);
    bus_if.stall  = 1'b0;
    bus_if.addbus = 40'h0;
    #1;
    n_checks++;
    if ({bus_if.in_take1, bus_if.in_take2} !== 2'b11) begin
      n_fail++;
      $display("FAIL stall_release_take: got %b, required 11", {bus_if.in_take1, bus_if.in_take2});
    end
    push_exp(1'b0, 40'h01_01_11_10_12, 16'h0304);
    push_exp(1'b1, 40'h06_04_01_00_13, 16'h0306);
    tick();
    @(negedge clk);
    idle_inputs();
    tick();
    check_drained("stall");
  endtask

  task automatic test_page_fault();
    do_reset();
    @(negedge clk);
    slots(1'b1, 32'h04_10_00_12, 16'h0400, 1'b0, 32'h0, 16'h0);
    push_exp(1'b0, 40'h06_04_10_00_12, 16'h0400);
    tick();
    @(negedge clk);
    slots(1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 16'h0);
    bus_if.loadbus = {8'h06, 32'hffff_ffff};
    tick();
    @(negedge clk);
    bus_if.loadbus = 40'h0;
    slots(1'b1, 32'h01_12_12_13, 16'h0404, 1'b1, 32'h04_12_00_11, 16'h0408);
    push_exp(1'b0, 40'h01_01_06_06_13, 16'h0404);
    push_exp(1'b1, 40'h07_04_06_00_11, 16'h0408);
    tick();
    @(negedge clk);
    slots(1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 16'h0);
    bus_if.loadbus = {8'h06, 32'h0000_0005};
    tick();
    @(negedge clk);
    bus_if.loadbus = 40'h0;
    slots(1'b1, 32'h01_12_12_10, 16'h040C, 1'b1, 32'h04_10_00_11, 16'h0410);
    push_exp(1'b0, 40'h02_01_12_12_10, 16'h040C);
    push_exp(1'b1, 40'h06_04_02_00_11, 16'h0410);
    tick();
    @(negedge clk);
    idle_inputs();
    tick();
    check_drained("page_fault");
  endtask

  task automatic test_illegal();
    do_reset();
    @(negedge clk);
    slots(1'b1, 32'h7F_10_11_12, 16'h04F0, 1'b1, 32'h01_10_11_13, 16'h04F4);
    #1;
    n_checks++;
    if ({bus_if.in_take1, bus_if.in_take2} !== 2'b10) begin
      n_fail++;
      $display("FAIL illegal1_take: got %b, required 10", {bus_if.in_take1, bus_if.in_take2});
    end
    tick();
    n_checks++;
    if ({bus_if.illegal_op, bus_if.inst_valid1, bus_if.inst_valid2} !== 3'b100) begin
      n_fail++;
      $display("FAIL illegal1_pulse: got illegal/v1/v2=%b, required 100",
               {bus_if.illegal_op, bus_if.inst_valid1, bus_if.inst_valid2});
    end
    @(negedge clk);
    slots(1'b1, 32'h01_10_11_12, 16'h0500, 1'b1, 32'h00_10_10_10, 16'h0504);
    #1;
    n_checks++;
    if ({bus_if.in_take1, bus_if.in_take2} !== 2'b11) begin
      n_fail++;
      $display("FAIL illegal2_take: got %b, required 11", {bus_if.in_take1, bus_if.in_take2});
    end
    push_exp(1'b0, 40'h01_01_10_11_12, 16'h0500);
    tick();
    n_checks++;
    if ({bus_if.illegal_op, bus_if.inst_valid2} !== 2'b10) begin
      n_fail++;
      $display("FAIL illegal2_pulse: got illegal/v2=%b, required 10",
               {bus_if.illegal_op, bus_if.inst_valid2});
    end
    @(negedge clk);
    idle_inputs();
    tick();
    n_checks++;
    if (bus_if.illegal_op !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_one_cycle: got %b, required 0", bus_if.illegal_op);
    end
    check_drained("illegal");
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    slots(1'b1, 32'h01_10_10_10, 16'h0600, 1'b1, 32'h01_11_11_11, 16'h0604);
    push_exp(1'b0, 40'h01_01_10_10_10, 16'h0600);
    push_exp(1'b1, 40'h02_01_11_11_11, 16'h0604);
    tick();
    @(negedge clk);
    slots(1'b1, 32'h01_12_12_12, 16'h0608, 1'b1, 32'h03_10_11_13, 16'h060C);
    push_exp(1'b0, 40'h03_01_12_12_12, 16'h0608);
    push_exp(1'b1, 40'h04_03_01_02_13, 16'h060C);
    tick();
    @(negedge clk);
    slots(1'b1, 32'h03_13_13_10, 16'h0610, 1'b1, 32'h04_10_00_11, 16'h0614);
    push_exp(1'b0, 40'h05_03_04_04_10, 16'h0610);
    push_exp(1'b1, 40'h06_04_05_00_11, 16'h0614);
    tick();
    @(negedge clk);
    slots(1'b1, 32'h04_11_00_12, 16'h0618, 1'b0, 32'h0, 16'h0);
    push_exp(1'b0, 40'h07_04_06_00_12, 16'h0618);
    tick();
    @(negedge clk);
    slots(1'b1, 32'h01_12_10_11, 16'h0620, 1'b1, 32'h03_11_12_13, 16'h0624);
    #1;
    n_checks++;
    if ({bus_if.in_take1, bus_if.in_take2} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_take: got %b, required 00", {bus_if.in_take1, bus_if.in_take2});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.in_take1, bus_if.inst_valid1, bus_if.inst_valid2} !== 3'b000 ||
        bus_if.instbus1 !== 40'h0 || bus_if.pc2 !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: got take/v1/v2=%b bus1=%h pc2=%h, required 000 0 0",
               {bus_if.in_take1, bus_if.inst_valid1, bus_if.inst_valid2},
               bus_if.instbus1, bus_if.pc2);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.in_take1, bus_if.in_take2} !== 2'b11) begin
      n_fail++;
      $display("FAIL post_reset_take: got %b, required 11", {bus_if.in_take1, bus_if.in_take2});
    end
    push_exp(1'b0, 40'h01_01_12_10_11, 16'h0620);
    push_exp(1'b1, 40'h04_03_01_12_13, 16'h0624);
    tick();
    @(negedge clk);
    slots(1'b1, 32'h04_13_00_10, 16'h0628, 1'b0, 32'h0, 16'h0);
    push_exp(1'b0, 40'h06_04_04_00_10, 16'h0628);
    tick();
    @(negedge clk);
    idle_inputs();
    tick();
    check_drained("reset_mid");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_dual_issue();
    test_add_exhaust();
    test_stall();
    test_page_fault();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
